// File: rtl/noise_matrix_reader_if.sv
// ---------------------------------------------------------------------------
// noise_matrix_reader_if
//   Bundles the control, BRAM read-port and output-stream signals of
//   noise_matrix_reader.
//
//   Signals:
//     start       request to stream one matrix (one-cycle pulse)
//     size        matrix side code, side = 4 << size (6 and 7 act as 5)
//     bram_addr   BRAM read address
//     bram_en     BRAM read enable; bram_rdata is valid one cycle later
//     bram_rdata  BRAM read data
//     m_data      stream sample
//     m_valid     m_data valid
//     m_ready     downstream ready; a beat moves when m_valid & m_ready
//     m_last      final sample of the matrix
//     busy        a matrix is being streamed
//     done        one-cycle pulse after the final sample is accepted
//     m_row_last  last sample of each row (only with NOISE_READER_ROW_LAST_EN)
//
//   Modports:
//     master  the reader side (drives BRAM requests and the output stream)
//     slave   the environment side (controller, BRAM and stream sink)
//
//   Build option: defining NOISE_READER_ROW_LAST_EN adds m_row_last.
// ---------------------------------------------------------------------------
interface noise_matrix_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
);
  logic                  start;
  logic [2:0]            size;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic                  bram_en;
  logic [DATA_WIDTH-1:0] bram_rdata;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  busy;
  logic                  done;
`ifdef NOISE_READER_ROW_LAST_EN
  logic                  m_row_last;
`endif

  modport master (
    input  start,
    input  size,
    input  bram_rdata,
    input  m_ready,
    output bram_addr,
    output bram_en,
    output m_data,
    output m_valid,
    output m_last,
    output busy,
    output done
`ifdef NOISE_READER_ROW_LAST_EN
    ,
    output m_row_last
`endif
  );

  modport slave (
    output start,
    output size,
    output bram_rdata,
    output m_ready,
    input  bram_addr,
    input  bram_en,
    input  m_data,
    input  m_valid,
    input  m_last,
    input  busy,
    input  done
`ifdef NOISE_READER_ROW_LAST_EN
    ,
    input  m_row_last
`endif
  );
endinterface

// File: rtl/noise_matrix_reader.sv
// ---------------------------------------------------------------------------
// noise_matrix_reader
//   Streams a square noise matrix (side 4..128, row-major) out of a BRAM
//   with one-cycle read latency. Returned words land in a 2-entry FIFO whose
//   head drives the valid/ready output stream, so full throughput is kept
//   with m_ready high and nothing is lost or duplicated under backpressure.
//
//   Ports:
//     clk   single clock, all state on the rising edge
//     rst   asynchronous active-high reset; aborts any stream, flushes FIFO
//     bus   noise_matrix_reader_if.master (start/size, BRAM read port,
//           output stream m_data/m_valid/m_ready/m_last, busy, done)
//
//   Parameters:
//     DATA_WIDTH  width of one noise sample
//     ADDR_WIDTH  BRAM address width (14 covers a full 128x128 matrix)
//
//   Build option: NOISE_READER_ROW_LAST_EN adds m_row_last, driven from a
//   column counter that travels through the FIFO with each sample.
// ---------------------------------------------------------------------------
module noise_matrix_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  noise_matrix_reader_if.master  bus
);

  // Element counter is one bit wider than the address so that the terminal
  // count of a full 2^ADDR_WIDTH matrix is representable.
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_addr_cnt;   // next address to read
  logic [CW-1:0]         r_n;          // element count of current matrix
  logic                  r_busy;
  logic                  r_done;

  // Read-return tracking: a read issued in cycle C has its data on
  // bram_rdata in C+1, where r_rvalid marks it for capture.
  logic                  r_rvalid;
  logic                  r_rd_last;

  // 2-entry output FIFO
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]            r_fifo_last;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic [2:0]            w_size_clamped;
  logic [CW-1:0]         w_n_calc;
  logic                  w_start_accept;
  logic                  w_m_valid;
  logic                  w_m_last;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_credit_ok;
  logic                  w_issue;
  logic                  w_issue_last;

`ifdef NOISE_READER_ROW_LAST_EN
  logic [7:0]            r_col_cnt;    // column of the next read
  logic [7:0]            r_side_m1;    // side - 1
  logic                  r_rd_row;     // row-last tag for the returning read
  logic [1:0]            r_fifo_row;
  logic [7:0]            w_side_m1_calc;
`endif

  // -------------------------------------------------------------------------
  // Matrix geometry from the size code
  // -------------------------------------------------------------------------
  assign w_size_clamped = (bus.size > 3'd5) ? 3'd5 : bus.size;
  // N = 16 << (2*size)
  assign w_n_calc       = CW'(32'd16 << {w_size_clamped, 1'b0});
  assign w_start_accept = (r_state == ST_IDLE) && bus.start;

  // -------------------------------------------------------------------------
  // Stream handshake and read issue
  // -------------------------------------------------------------------------
  assign w_m_valid    = (r_count != 2'd0);
  assign w_m_last     = w_m_valid & r_fifo_last[r_rd_ptr];
  assign w_pop        = w_m_valid & bus.m_ready;
  assign w_push       = r_rvalid;

  // Occupancy is counted after this cycle's pop so a steady stream keeps one
  // word in the FIFO and one read in flight, i.e. one sample per cycle,
  // while total outstanding words never exceed the two FIFO slots.
  assign w_credit_ok  = (({1'b0, r_count} + {2'b00, r_rvalid}) - {2'b00, w_pop}) < 3'd2;
  assign w_issue      = (r_state == ST_STREAM) && (r_addr_cnt < r_n) && w_credit_ok;
  assign w_issue_last = (r_addr_cnt == (r_n - CW'(1)));

  assign bus.bram_en   = w_issue;
  assign bus.bram_addr = r_addr_cnt[ADDR_WIDTH-1:0];
  assign bus.m_data    = r_fifo_data[r_rd_ptr];
  assign bus.m_valid   = w_m_valid;
  assign bus.m_last    = w_m_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  // -------------------------------------------------------------------------
  // Control FSM with registered busy/done
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr_cnt <= '0;
      r_n        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_start_accept) begin
            r_n        <= w_n_calc;
            r_addr_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // start is not looked at here, so a start coinciding with the
          // last beat does not re-arm the reader.
          if (w_issue) begin
            r_addr_cnt <= r_addr_cnt + CW'(1);
          end
          if (w_pop && w_m_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read-return capture and output FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Clearing r_rvalid drops any read that was in flight at reset.
      r_rvalid    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_last <= '0;
`ifdef NOISE_READER_ROW_LAST_EN
      r_fifo_row  <= '0;
`endif
    end else begin
      r_rvalid  <= w_issue;
      r_rd_last <= w_issue & w_issue_last;
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bus.bram_rdata;
        r_fifo_last[r_wr_ptr] <= r_rd_last;
`ifdef NOISE_READER_ROW_LAST_EN
        r_fifo_row[r_wr_ptr]  <= r_rd_row;
`endif
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= (r_count + {1'b0, w_push}) - {1'b0, w_pop};
    end
  end

`ifdef NOISE_READER_ROW_LAST_EN
  // -------------------------------------------------------------------------
  // Column counter: follows the issued addresses and tags each read with a
  // row-last flag that rides through the FIFO next to its data word.
  // -------------------------------------------------------------------------
  assign w_side_m1_calc = (8'd4 << w_size_clamped) - 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_cnt <= 8'd0;
      r_side_m1 <= 8'd0;
      r_rd_row  <= 1'b0;
    end else begin
      if (w_start_accept) begin
        r_col_cnt <= 8'd0;
        r_side_m1 <= w_side_m1_calc;
      end else if (w_issue) begin
        r_col_cnt <= (r_col_cnt == r_side_m1) ? 8'd0 : (r_col_cnt + 8'd1);
      end
      r_rd_row <= (r_col_cnt == r_side_m1);
    end
  end

  assign bus.m_row_last = w_m_valid & r_fifo_row[r_rd_ptr];
`endif

endmodule

// File: tb/tb_noise_matrix_reader.sv
// ---------------------------------------------------------------------------
// tb_noise_matrix_reader
//   Self-checking bench for noise_matrix_reader. A BRAM model with one-cycle
//   read latency feeds the DUT; a negedge monitor records issued addresses,
//   accepted beats, stall stability and outstanding reads. Each test task
//   compares what was recorded against expectations computed from the
//   matrix rules (N = 16 * 4^min(size,5), data = mem[0..N-1] in order).
// ---------------------------------------------------------------------------
module tb_noise_matrix_reader;

  localparam int DW        = 16;
  localparam int AW        = 14;
  localparam int MEM_WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noise_matrix_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  noise_matrix_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // BRAM model: data appears one cycle after the enabled read.
  logic [DW-1:0] mem [MEM_WORDS];
  always @(posedge clk) begin
    if (rst) bus.bram_rdata <= '0;
    else if (bus.bram_en === 1'b1) bus.bram_rdata <= mem[bus.bram_addr];
  end

  // Downstream ready generator: 0 = always ready, 1 = pattern 1,0,0,1,
  // 2 = random (~75 % ready).
  int ready_mode = 0;
  int pat_idx    = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.m_ready = 1'b1;
      1: begin
        bus.m_ready = (pat_idx == 0) || (pat_idx == 3);
        pat_idx     = (pat_idx + 1) % 4;
      end
      2: bus.m_ready = ($urandom_range(0, 3) != 0);
      default: bus.m_ready = 1'b0;
    endcase
  end

  // Monitor
  logic [DW-1:0] dq [$];
  bit            lq [$];
  bit            rq [$];
  int            iq [$];
  int            outs       = 0;
  int            max_outs   = 0;
  int            stall_errs = 0;
  int            done_cnt   = 0;
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_rl = 1'b0;
  logic [DW-1:0] prev_d = '0;

  always @(negedge clk) begin
    if (rst) begin
      outs   = 0;
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (prev_v === 1'b1 && prev_r === 1'b0) begin
        if (bus.m_valid !== 1'b1 || bus.m_data !== prev_d || bus.m_last !== prev_l) stall_errs++;
`ifdef NOISE_READER_ROW_LAST_EN
        if (bus.m_row_last !== prev_rl) stall_errs++;
`endif
      end
      if (bus.bram_en === 1'b1) begin
        iq.push_back(int'(bus.bram_addr));
        outs++;
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        dq.push_back(bus.m_data);
        lq.push_back(bus.m_last);
`ifdef NOISE_READER_ROW_LAST_EN
        rq.push_back(bus.m_row_last);
`endif
        outs--;
      end
      if (outs > max_outs) max_outs = outs;
      if (bus.done === 1'b1) done_cnt++;
      prev_v = bus.m_valid;
      prev_r = bus.m_ready;
      prev_d = bus.m_data;
      prev_l = bus.m_last;
`ifdef NOISE_READER_ROW_LAST_EN
      prev_rl = bus.m_row_last;
`endif
    end
  end

  // Stimulus helpers
  task automatic pulse_start(input logic [2:0] s);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.size  = s;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  function automatic int matrix_n(input int sz);
    int sc;
    sc = (sz > 5) ? 5 : sz;
    return 16 * (4 ** sc);
  endfunction

  // ------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.bram_en, bus.m_valid, bus.m_last, bus.busy, bus.done} !== 5'b0) begin
      $display("FAIL reset_ctrl: en/valid/last/busy/done got %b expected 00000",
               {bus.bram_en, bus.m_valid, bus.m_last, bus.busy, bus.done});
    end else n_pass++;
    n_checks++;
    if (bus.bram_addr !== '0) $display("FAIL reset_addr: got %0d expected 0", bus.bram_addr);
    else n_pass++;
    n_checks++;
    if (bus.m_data !== '0) $display("FAIL reset_data: got %0h expected 0", bus.m_data);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // size 0, always ready: cycle-exact timing of the 16-beat stream
  task automatic test_size0_stream();
    int base, first_valid, v_err, d_err, l_err, dn_err, b_err;
    bit exp_v;
    ready_mode = 0;
    base = dq.size();
    first_valid = -1;
    v_err = 0; d_err = 0; l_err = 0; dn_err = 0; b_err = 0;
    pulse_start(3'd0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp_v = (k >= 3) && (k <= 18);
      if (bus.m_valid !== exp_v) v_err++;
      if (exp_v && bus.m_data !== DW'(k - 3)) d_err++;
      if (bus.m_last !== (k == 18)) l_err++;
      if (bus.done !== (k == 19)) dn_err++;
      if (bus.busy !== (k <= 18)) b_err++;
      if (first_valid < 0 && bus.m_valid === 1'b1) first_valid = k;
    end
    n_checks++;
    if (first_valid != 3) $display("FAIL s0_first_valid: got cycle %0d expected 3", first_valid);
    else n_pass++;
    n_checks++;
    if (v_err != 0) $display("FAIL s0_valid_timing: got %0d bad cycles expected 0", v_err);
    else n_pass++;
    n_checks++;
    if (d_err != 0) $display("FAIL s0_data: got %0d bad beats expected 0", d_err);
    else n_pass++;
    n_checks++;
    if (l_err != 0) $display("FAIL s0_last: got %0d bad cycles expected 0", l_err);
    else n_pass++;
    n_checks++;
    if (dn_err != 0) $display("FAIL s0_done: got %0d bad cycles expected 0", dn_err);
    else n_pass++;
    n_checks++;
    if (b_err != 0) $display("FAIL s0_busy: got %0d bad cycles expected 0", b_err);
    else n_pass++;
    n_checks++;
    if (dq.size() - base != 16) $display("FAIL s0_count: got %0d expected 16", dq.size() - base);
    else n_pass++;
  endtask

  // size 1 with ready pattern 1,0,0,1
  task automatic test_backpressure();
    int base, ibase, dbase, sbase, n, d_err, l_err, a_err;
    bit seen;
    ready_mode = 1;
    base = dq.size(); ibase = iq.size(); dbase = done_cnt; sbase = stall_errs;
    pulse_start(3'd1);
    wait_done(2000, seen);
    repeat (3) @(negedge clk);
    ready_mode = 0;
    n = dq.size() - base;
    d_err = 0; l_err = 0; a_err = 0;
    for (int i = 0; i < n; i++) begin
      if (dq[base + i] !== mem[i]) d_err++;
      if (lq[base + i] != (i == 63)) l_err++;
    end
    for (int i = 0; i < iq.size() - ibase; i++) if (iq[ibase + i] != i) a_err++;
    n_checks++;
    if (!seen) $display("FAIL bp_done_timeout: got no done expected done within 2000 cycles");
    else n_pass++;
    n_checks++;
    if (n != 64) $display("FAIL bp_count: got %0d expected 64", n);
    else n_pass++;
    n_checks++;
    if (d_err != 0 || l_err != 0) $display("FAIL bp_data_last: got %0d/%0d bad beats expected 0/0", d_err, l_err);
    else n_pass++;
    n_checks++;
    if (a_err != 0 || iq.size() - ibase != 64)
      $display("FAIL bp_addr_order: got %0d bad of %0d reads expected 0 of 64", a_err, iq.size() - ibase);
    else n_pass++;
    n_checks++;
    if (stall_errs != sbase) $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_errs - sbase);
    else n_pass++;
    n_checks++;
    if (max_outs > 2) $display("FAIL bp_outstanding: got %0d expected <=2", max_outs);
    else n_pass++;
    n_checks++;
    if (done_cnt - dbase != 1) $display("FAIL bp_done_count: got %0d expected 1", done_cnt - dbase);
    else n_pass++;
  endtask

  // start re-pulsed mid-stream, on the last beat and in FINISH
  task automatic test_start_ignored();
    int base, dbase, d_err;
    ready_mode = 0;
    base = dq.size(); dbase = done_cnt;
    pulse_start(3'd0);
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk); #1;
      bus.start = (k == 5) || (k == 18) || (k == 19);
      bus.size  = 3'd1;
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    d_err = 0;
    for (int i = 0; i < dq.size() - base; i++) if (dq[base + i] !== mem[i]) d_err++;
    n_checks++;
    if (dq.size() - base != 16) $display("FAIL ign_count: got %0d expected 16", dq.size() - base);
    else n_pass++;
    n_checks++;
    if (done_cnt - dbase != 1) $display("FAIL ign_done_count: got %0d expected 1", done_cnt - dbase);
    else n_pass++;
    n_checks++;
    if (d_err != 0) $display("FAIL ign_data: got %0d bad beats expected 0", d_err);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL ign_busy_end: got %b expected 0", bus.busy);
    else n_pass++;
  endtask

`ifdef NOISE_READER_ROW_LAST_EN
  task automatic test_row_last();
    int base, r_err;
    bit seen;
    ready_mode = 0;
    base = rq.size();
    pulse_start(3'd0);
    wait_done(200, seen);
    repeat (3) @(negedge clk);
    r_err = 0;
    for (int i = 0; i < rq.size() - base; i++) if (rq[base + i] != ((i % 4) == 3)) r_err++;
    n_checks++;
    if (!seen || rq.size() - base != 16) $display("FAIL row_count: got %0d beats expected 16", rq.size() - base);
    else n_pass++;
    n_checks++;
    if (r_err != 0) $display("FAIL row_last: got %0d bad beats expected 0", r_err);
    else n_pass++;
  endtask
`endif

  // size 2 interrupted by reset after 10 beats, then restarted
  task automatic test_reset_midstream();
    int base, ibase, d_err, a_err;
    bit seen;
    ready_mode = 0;
    base = dq.size();
    pulse_start(3'd2);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #2;
      if (dq.size() - base >= 10) break;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.bram_en, bus.m_valid, bus.m_last, bus.busy, bus.done} !== 5'b0)
      $display("FAIL rst_mid_ctrl: en/valid/last/busy/done got %b expected 00000",
               {bus.bram_en, bus.m_valid, bus.m_last, bus.busy, bus.done});
    else n_pass++;
    n_checks++;
    if (bus.bram_addr !== '0 || bus.m_data !== '0)
      $display("FAIL rst_mid_addr_data: got addr %0d data %0h expected 0 0", bus.bram_addr, bus.m_data);
    else n_pass++;
    n_checks++;
    if (dq.size() - base != 10) $display("FAIL rst_mid_beats: got %0d expected 10", dq.size() - base);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    base = dq.size(); ibase = iq.size();
    pulse_start(3'd2);
    wait_done(1000, seen);
    repeat (3) @(negedge clk);
    d_err = 0; a_err = 0;
    for (int i = 0; i < dq.size() - base; i++) if (dq[base + i] !== mem[i]) d_err++;
    for (int i = 0; i < iq.size() - ibase; i++) if (iq[ibase + i] != i) a_err++;
    n_checks++;
    if (!seen || dq.size() - base != 256) $display("FAIL rst_restart_count: got %0d expected 256", dq.size() - base);
    else n_pass++;
    n_checks++;
    if (d_err != 0 || a_err != 0) $display("FAIL rst_restart_order: got %0d data / %0d addr errors expected 0/0", d_err, a_err);
    else n_pass++;
  endtask

  // size 7 clamps to the full 128x128 matrix
  task automatic test_size7_clamp();
    int base, ibase, n, d_err, l_err;
    bit seen;
    ready_mode = 0;
    base = dq.size(); ibase = iq.size();
    pulse_start(3'd7);
    wait_done(20000, seen);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL s7_busy_after_done: got %b expected 0", bus.busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    n = dq.size() - base;
    d_err = 0; l_err = 0;
    for (int i = 0; i < n; i++) begin
      if (dq[base + i] !== mem[i]) d_err++;
      if (lq[base + i] != (i == 16383)) l_err++;
    end
    n_checks++;
    if (!seen || n != 16384) $display("FAIL s7_count: got %0d expected 16384", n);
    else n_pass++;
    n_checks++;
    if (d_err != 0 || l_err != 0) $display("FAIL s7_data_last: got %0d/%0d bad beats expected 0/0", d_err, l_err);
    else n_pass++;
    n_checks++;
    if (iq.size() - ibase != 16384 || iq[iq.size() - 1] != 16383)
      $display("FAIL s7_last_addr: got %0d reads ending at %0d expected 16384 ending at 16383",
               iq.size() - ibase, iq[iq.size() - 1]);
    else n_pass++;
  endtask

  // random sizes 0..3, random BRAM contents, random backpressure
  task automatic test_random_ready();
    int base, ibase, sbase, n, sz, d_err, l_err, a_err;
    bit seen;
    logic [DW-1:0] exp_q [$];
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 1024; a++) mem[a] = DW'($urandom);
      sz = $urandom_range(0, 3);
      n  = matrix_n(sz);
      exp_q.delete();
      for (int a = 0; a < n; a++) exp_q.push_back(mem[a]);
      ready_mode = 2;
      base = dq.size(); ibase = iq.size(); sbase = stall_errs;
      pulse_start(3'(sz));
      wait_done(20000, seen);
      repeat (3) @(negedge clk);
      ready_mode = 0;
      d_err = 0; l_err = 0; a_err = 0;
      for (int i = 0; i < dq.size() - base && i < n; i++) begin
        if (dq[base + i] !== exp_q[i]) d_err++;
        if (lq[base + i] != (i == n - 1)) l_err++;
      end
      for (int i = 0; i < iq.size() - ibase; i++) if (iq[ibase + i] != i) a_err++;
      n_checks++;
      if (!seen || dq.size() - base != n)
        $display("FAIL rnd%0d_count: size %0d got %0d beats expected %0d", r, sz, dq.size() - base, n);
      else n_pass++;
      n_checks++;
      if (d_err != 0 || l_err != 0)
        $display("FAIL rnd%0d_data_last: got %0d/%0d bad beats expected 0/0", r, d_err, l_err);
      else n_pass++;
      n_checks++;
      if (a_err != 0 || iq.size() - ibase != n)
        $display("FAIL rnd%0d_addr: got %0d bad of %0d reads expected 0 of %0d", r, a_err, iq.size() - ibase, n);
      else n_pass++;
      n_checks++;
      if (stall_errs != sbase || max_outs > 2)
        $display("FAIL rnd%0d_stall_outs: got %0d changes, max %0d outstanding expected 0, <=2",
                 r, stall_errs - sbase, max_outs);
      else n_pass++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.size  = 3'd0;
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = DW'(a);
    test_reset();
    test_size0_stream();
    test_backpressure();
    test_start_ignored();
`ifdef NOISE_READER_ROW_LAST_EN
    test_row_last();
`endif
    test_reset_midstream();
    test_size7_clamp();
    test_random_ready();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
